// File: rtl/mem_responder_if.sv
// Request/response bundle between the core's memory port and mem_responder.
// The core drives the request side and consumes the response side.
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 32
) ();

  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [ADDR_WIDTH-1:0] mem_address_i;
  logic [31:0]           req_wdata_i;
  logic [3:0]            req_wstrb_i;
  logic                  resp_valid_o;
  logic                  resp_ready_i;
  logic [31:0]           resp_rdata_o;
  logic                  resp_error_o;

  // Core side of the port.
  modport master (
    output req_valid_i,
    input  req_ready_o,
    output req_write_i,
    output mem_address_i,
    output req_wdata_i,
    output req_wstrb_i,
    input  resp_valid_o,
    output resp_ready_i,
    input  resp_rdata_o,
    input  resp_error_o
  );

  // Memory side of the port.
  modport slave (
    input  req_valid_i,
    output req_ready_o,
    input  req_write_i,
    input  mem_address_i,
    input  req_wdata_i,
    input  req_wstrb_i,
    output resp_valid_o,
    input  resp_ready_i,
    output resp_rdata_o,
    output resp_error_o
  );

endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one read/write request at a time, performs
// it on a word-organised RAM after LATENCY cycles, then holds the response
// until the core takes it. Only one transaction is ever in flight.
module mem_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mem_responder_if.slave bus
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [CNT_W-1:0]      CNT_LOAD    = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]      CNT_ONE     = CNT_W'(1);
  // Range limit kept at full address width so high addresses never alias.
  localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(DEPTH_WORDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Merge the enabled byte lanes of new_word into old_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end else begin
        merged[8*i +: 8] = old_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

  logic [31:0]           mem_r [DEPTH_WORDS];

  logic [1:0]            state_r;
  logic                  ready_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                  write_r;
  logic [31:0]           wdata_r;
  logic [3:0]            wstrb_r;
  logic                  resp_valid_r;
  logic [31:0]           rdata_r;
  logic                  error_r;

  logic                  accept_s;
  logic                  resp_hs_s;
  logic                  access_s;
  logic [ADDR_WIDTH-1:0] acc_addr_s;
  logic                  acc_write_s;
  logic [31:0]           acc_wdata_s;
  logic [3:0]            acc_wstrb_s;
  logic [ADDR_WIDTH-3:0] word_idx_s;
  logic                  in_range_s;
  logic                  acc_err_s;
  logic [IDX_W-1:0]      ram_idx_s;
  logic [31:0]           ram_word_s;
  logic [31:0]           result_rdata_s;

  assign accept_s  = (state_r == ST_IDLE) && ready_r && bus.req_valid_i && !rst_i;
  assign resp_hs_s = resp_valid_r && bus.resp_ready_i;

  // Access operands: live request when the access happens on the accept edge
  // (single-cycle latency), otherwise the captured holding registers.
  always_comb begin
    acc_addr_s  = addr_r;
    acc_write_s = write_r;
    acc_wdata_s = wdata_r;
    acc_wstrb_s = wstrb_r;
    if (state_r == ST_IDLE) begin
      acc_addr_s  = bus.mem_address_i;
      acc_write_s = bus.req_write_i;
      acc_wdata_s = bus.req_wdata_i;
      acc_wstrb_s = bus.req_wstrb_i;
    end else begin
      acc_addr_s  = addr_r;
      acc_write_s = write_r;
      acc_wdata_s = wdata_r;
      acc_wstrb_s = wstrb_r;
    end
  end

  // Decide whether the RAM access happens on the coming edge.
  always_comb begin
    access_s = 1'b0;
    if (rst_i) begin
      access_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: access_s = accept_s && (LATENCY == 1);
        ST_BUSY: access_s = (cnt_r == CNT_ONE);
        default: access_s = 1'b0;
      endcase
    end
  end

  assign word_idx_s = acc_addr_s[ADDR_WIDTH-1:2];
  assign in_range_s = ({2'b00, word_idx_s} < DEPTH_LIMIT);
  assign acc_err_s  = (acc_addr_s[1:0] != 2'b00) || !in_range_s;
  assign ram_idx_s  = word_idx_s[IDX_W-1:0];
  assign ram_word_s = mem_r[ram_idx_s];

  // Response data: RAM word for good reads, zero for writes and errors.
  always_comb begin
    result_rdata_s = 32'h0000_0000;
    if (acc_write_s || acc_err_s) begin
      result_rdata_s = 32'h0000_0000;
    end else begin
      result_rdata_s = ram_word_s;
    end
  end

  // RAM array: byte-lane write on a good write access; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (access_s && acc_write_s && !acc_err_s) begin
      mem_r[ram_idx_s] <= merge_bytes(ram_word_s, acc_wdata_s, acc_wstrb_s);
    end
  end

  // Transaction FSM, holding registers, latency counter and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      ready_r      <= 1'b0;
      cnt_r        <= '0;
      addr_r       <= '0;
      write_r      <= 1'b0;
      wdata_r      <= 32'h0000_0000;
      wstrb_r      <= 4'h0;
      resp_valid_r <= 1'b0;
      rdata_r      <= 32'h0000_0000;
      error_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            addr_r  <= bus.mem_address_i;
            write_r <= bus.req_write_i;
            wdata_r <= bus.req_wdata_i;
            wstrb_r <= bus.req_wstrb_i;
            cnt_r   <= CNT_LOAD;
            ready_r <= 1'b0;
            if (access_s) begin
              state_r      <= ST_RESP;
              resp_valid_r <= 1'b1;
              rdata_r      <= result_rdata_s;
              error_r      <= acc_err_s;
            end else begin
              state_r <= ST_BUSY;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        ST_BUSY: begin
          cnt_r <= cnt_r - CNT_ONE;
          if (access_s) begin
            state_r      <= ST_RESP;
            resp_valid_r <= 1'b1;
            rdata_r      <= result_rdata_s;
            error_r      <= acc_err_s;
          end
        end
        ST_RESP: begin
          if (resp_hs_s) begin
            state_r      <= ST_IDLE;
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            rdata_r      <= 32'h0000_0000;
            error_r      <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          ready_r      <= 1'b0;
          resp_valid_r <= 1'b0;
          rdata_r      <= 32'h0000_0000;
          error_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_o  = ready_r;
  assign bus.resp_valid_o = resp_valid_r;
  assign bus.resp_rdata_o = rdata_r;
  assign bus.resp_error_o = error_r;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (LATENCY 1, 2, 4) sharing a clock,
// driven by directed steps plus a randomized phase, checked against a
// word-array reference model of the memory.
module tb_mem_responder;

  localparam int NU = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst        [NU];
  logic        req_valid  [NU];
  logic        req_write  [NU];
  logic [31:0] addr       [NU];
  logic [31:0] wdata      [NU];
  logic [3:0]  wstrb      [NU];
  logic        resp_ready [NU];
  logic        req_ready  [NU];
  logic        resp_valid [NU];
  logic [31:0] rdata      [NU];
  logic        error      [NU];

  generate
    for (genvar g = 0; g < NU; g++) begin : u
      localparam int L = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
      mem_responder_if #(.ADDR_WIDTH(32)) ifc ();
      assign ifc.req_valid_i   = req_valid[g];
      assign ifc.req_write_i   = req_write[g];
      assign ifc.mem_address_i = addr[g];
      assign ifc.req_wdata_i   = wdata[g];
      assign ifc.req_wstrb_i   = wstrb[g];
      assign ifc.resp_ready_i  = resp_ready[g];
      assign req_ready[g]      = ifc.req_ready_o;
      assign resp_valid[g]     = ifc.resp_valid_o;
      assign rdata[g]          = ifc.resp_rdata_o;
      assign error[g]          = ifc.resp_error_o;
      mem_responder #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .LATENCY(L)) dut (
        .clk_i (clk),
        .rst_i (rst[g]),
        .bus   (ifc.slave)
      );
    end
  endgenerate

  // Reference memory per instance, with a "written" flag per word.
  logic [31:0] ref_mem   [NU][1024];
  bit          ref_known [NU][1024];

  int checks = 0;
  int errors = 0;

  logic [31:0] last_rdata;
  logic        last_error;
  int          last_acc;
  int          last_hs;

  function automatic int lat_of(input int un);
    case (un)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One complete transaction on instance un, with 'stall' cycles of response backpressure.
  task automatic txn(input int un, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] ws, input int stall, input string tag);
    int          k;
    int          w;
    bit          err_e;
    bit          known;
    logic [31:0] exp_rd;
    logic [31:0] hold_rd;
    logic        hold_err;
    logic [31:0] merged;
    k = 0;
    while (req_ready[un] !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (req_ready[un] !== 1'b1) begin
      check({tag, "_ready_wait"}, 32'(req_ready[un]), 32'd1);
      return;
    end
    req_valid[un]  = 1'b1;
    req_write[un]  = wr;
    addr[un]       = a;
    wdata[un]      = wd;
    wstrb[un]      = ws;
    resp_ready[un] = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    last_acc = cyc;
    // Request inputs must not matter after the accept edge.
    req_valid[un] = 1'b0;
    addr[un]      = $urandom;
    wdata[un]     = $urandom;
    wstrb[un]     = 4'($urandom);
    req_write[un] = 1'($urandom);
    k = 1;
    while (resp_valid[un] !== 1'b1 && k < 20) begin
      check({tag, "_busy_ready"}, 32'(req_ready[un]), 32'd0);
      @(negedge clk);
      k++;
    end
    if (resp_valid[un] !== 1'b1) begin
      check({tag, "_valid_wait"}, 32'(resp_valid[un]), 32'd1);
      return;
    end
    check({tag, "_latency"}, 32'(k), 32'(lat_of(un)));
    err_e  = ((a % 32'd4) != 32'd0) || ((a / 32'd4) >= 32'd1024);
    w      = err_e ? 0 : int'(a / 32'd4);
    known  = ref_known[un][w];
    exp_rd = (err_e || wr) ? 32'd0 : ref_mem[un][w];
    check({tag, "_error"}, 32'(error[un]), 32'(err_e));
    if (wr || err_e || known) check({tag, "_rdata"}, rdata[un], exp_rd);
    check({tag, "_resp_ready"}, 32'(req_ready[un]), 32'd0);
    hold_rd  = rdata[un];
    hold_err = error[un];
    for (int s = 0; s < stall; s++) begin
      req_valid[un] = 1'($urandom);
      addr[un]      = $urandom;
      @(posedge clk);
      @(negedge clk);
      check({tag, "_stall_valid"}, 32'(resp_valid[un]), 32'd1);
      check({tag, "_stall_rdata"}, rdata[un], hold_rd);
      check({tag, "_stall_error"}, 32'(error[un]), 32'(hold_err));
      check({tag, "_stall_ready"}, 32'(req_ready[un]), 32'd0);
    end
    req_valid[un]  = 1'b0;
    resp_ready[un] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    last_hs = cyc;
    check({tag, "_done_valid"}, 32'(resp_valid[un]), 32'd0);
    check({tag, "_done_rdata"}, rdata[un], 32'd0);
    check({tag, "_done_error"}, 32'(error[un]), 32'd0);
    check({tag, "_done_ready"}, 32'(req_ready[un]), 32'd1);
    if (wr && !err_e) begin
      merged = ref_mem[un][w];
      for (int b = 0; b < 4; b++) begin
        if (ws[b]) merged[8*b +: 8] = wd[8*b +: 8];
      end
      // A partial write to an unknown word leaves the other lanes unknown.
      if (ws == 4'hF || known) begin
        ref_mem[un][w]   = merged;
        ref_known[un][w] = 1'b1;
      end
    end
    last_rdata = hold_rd;
    last_error = hold_err;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout cycles=%0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int          prev;
    int          w;
    int          r;
    logic [31:0] a;
    for (int i = 0; i < NU; i++) begin
      rst[i]        = 1'b1;
      req_valid[i]  = 1'b0;
      req_write[i]  = 1'b0;
      addr[i]       = 32'd0;
      wdata[i]      = 32'd0;
      wstrb[i]      = 4'h0;
      resp_ready[i] = 1'b1;
      for (int j = 0; j < 1024; j++) begin
        ref_mem[i][j]   = 32'd0;
        ref_known[i][j] = 1'b0;
      end
    end

    // Reset state.
    repeat (3) @(negedge clk);
    for (int i = 0; i < NU; i++) begin
      check("rst_req_ready", 32'(req_ready[i]), 32'd0);
      check("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
      check("rst_rdata", rdata[i], 32'd0);
      check("rst_error", 32'(error[i]), 32'd0);
    end
    for (int i = 0; i < NU; i++) rst[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NU; i++) check("post_rst_ready", 32'(req_ready[i]), 32'd1);

    // Full write then read back (LATENCY 2).
    txn(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, "w_beef");
    check("w_beef_hs_at", 32'(last_hs - last_acc), 32'd2);
    txn(1, 1'b0, 32'h10, 32'd0, 4'h0, 0, "r_beef");
    check("r_beef_value", last_rdata, 32'hDEADBEEF);

    // Partial write, single lane.
    txn(1, 1'b1, 32'h10, 32'h0000AA00, 4'h2, 0, "w_part");
    txn(1, 1'b0, 32'h10, 32'd0, 4'h0, 0, "r_part");
    check("r_part_value", last_rdata, 32'hDEADAAEF);

    // Legal no-op write.
    txn(1, 1'b1, 32'h10, 32'h11111111, 4'h0, 0, "w_noop");
    txn(1, 1'b0, 32'h10, 32'd0, 4'h0, 0, "r_noop");
    check("r_noop_value", last_rdata, 32'hDEADAAEF);

    // Backpressure with stray request pulses, then no extra response.
    txn(1, 1'b1, 32'h0, 32'h01234567, 4'hF, 0, "w_word0");
    txn(1, 1'b0, 32'h10, 32'd0, 4'h0, 5, "bp");
    check("bp_value", last_rdata, 32'hDEADAAEF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_no_extra", 32'(resp_valid[1]), 32'd0);
    end

    // Error cases.
    txn(1, 1'b0, 32'h13, 32'd0, 4'h0, 0, "r_misalign");
    check("r_misalign_err", 32'(last_error), 32'd1);
    txn(1, 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 0, "w_range");
    check("w_range_err", 32'(last_error), 32'd1);
    txn(1, 1'b0, 32'h0, 32'd0, 4'h0, 0, "r_word0");
    check("r_word0_value", last_rdata, 32'h01234567);
    txn(1, 1'b0, 32'hFFFFFFFC, 32'd0, 4'h0, 0, "r_high");

    // Reset while the write is still in flight.
    txn(1, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, "w_cafe");
    req_valid[1] = 1'b1;
    req_write[1] = 1'b1;
    addr[1]      = 32'h20;
    wdata[1]     = 32'h12345678;
    wstrb[1]     = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst[1]       = 1'b1;
    @(negedge clk);
    check("midrst_valid", 32'(resp_valid[1]), 32'd0);
    check("midrst_ready", 32'(req_ready[1]), 32'd0);
    @(negedge clk);
    rst[1] = 1'b0;
    @(negedge clk);
    check("midrst_ready_back", 32'(req_ready[1]), 32'd1);
    txn(1, 1'b0, 32'h20, 32'd0, 4'h0, 0, "r_cafe");
    check("r_cafe_value", last_rdata, 32'hCAFEF00D);

    // Back-to-back throughput for LATENCY 1 and 4.
    for (int un = 0; un < NU; un += 2) begin
      prev = 0;
      for (int i = 0; i < 4; i++) begin
        txn(un, (i < 2), 32'h40 + 32'(4 * (i % 2)), $urandom, 4'hF, 0, "b2b");
        check("b2b_hs_at", 32'(last_hs - last_acc), 32'(lat_of(un)));
        if (i > 0) check("b2b_accept_gap", 32'(last_acc - prev), 32'(lat_of(un) + 1));
        prev = last_acc;
      end
    end

    // Randomized traffic on the LATENCY 2 instance.
    for (int i = 0; i < 16; i++) txn(1, 1'b1, 32'(4 * i), $urandom, 4'hF, 0, "prime");
    for (int i = 0; i < 60; i++) begin
      w = $urandom_range(0, 15);
      a = 32'(4 * w);
      r = $urandom_range(0, 9);
      if (r == 0) a = a + 32'($urandom_range(1, 3));
      if (r == 1) a = 32'h1000 + a;
      if (r == 2) a = 32'hFFFF_0000 + a;
      txn(1, 1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the processor's data/instruction memory port. It accepts one request at a time (read or write) from the core through a valid/ready handshake.
- It performs the access on an internal word-organised RAM after a fixed, parameterised latency, then returns read data and an error flag through a response valid/ready handshake.
- It is the simulation and FPGA memory behind the pipeline's memory stage and fetch stage.

Parameters:
- ADDR_WIDTH, 32: width of the byte address.
- DEPTH_WORDS, 1024: number of 32-bit words in the RAM. Valid byte range is 0 to 4*DEPTH_WORDS-1.
- LATENCY, 2: cycles from request accept to first cycle of resp_valid_o. Must be at least 1.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_write_i  in  1  1 = write, 0 = read.
- mem_address_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  32  write data.
- req_wstrb_i  in  4  byte write enables; bit n enables byte lane n.
- resp_valid_o  out  1  response present.
- resp_ready_i  in  1  core accepts the response.
- resp_rdata_o  out  32  read data; 0 for writes and errors.
- resp_error_o  out  1  misaligned or out-of-range access.

Behaviour:
- Single clock domain. All state updates on the rising edge of clk_i.
- Reset (rst_i high at an edge):
  - state goes to IDLE.
  - req_ready_o = 0 while rst_i is high; req_ready_o = 1 from the first cycle after rst_i is low.
  - resp_valid_o = 0, resp_rdata_o = 0, resp_error_o = 0, latency counter = 0.
  - RAM contents are not reset.
- FSM states: IDLE, BUSY, RESP. One outstanding transaction; no pipelining.
- IDLE:
  - req_ready_o = 1.
  - A handshake (req_valid_i and req_ready_o both high at an edge) captures address, write, wdata and wstrb into holding registers, and loads cnt = LATENCY-1.
  - Next state is BUSY if LATENCY > 1, otherwise RESP, with the access performed on that edge.
- BUSY:
  - req_ready_o = 0.
  - cnt decrements each edge.
  - When cnt == 1, the access is performed and the state moves to RESP on that edge.
  - Result: resp_valid_o first asserts exactly LATENCY cycles after the accept edge.
- Access, performed once per transaction:
  - word index = captured address[ADDR_WIDTH-1:2].
  - Error when address[1:0] != 0 or word index >= DEPTH_WORDS. On error: RAM unchanged, rdata = 0, error = 1.
  - Read: rdata = RAM[index], error = 0.
  - Write: byte lanes with wstrb = 1 are updated from wdata, others are kept. rdata = 0, error = 0. wstrb = 0 is a legal no-op write.
- RESP:
  - resp_valid_o = 1, req_ready_o = 0.
  - resp_rdata_o and resp_error_o are held stable until the handshake (resp_valid_o and resp_ready_i both high at an edge).
  - On the handshake edge: resp_valid_o goes to 0, rdata and error go to 0, and the state returns to IDLE.
  - A new request can be accepted no earlier than the cycle after the response handshake. Peak throughput is one transaction per LATENCY+1 cycles.
- req_valid_i outside IDLE is ignored. Request inputs are not sampled except at the accept edge.
- Reset during BUSY discards the transaction; an uncommitted write never reaches the RAM.
- Reset during RESP drops the response; a write already committed stays in the RAM.
- The address comparison uses the full ADDR_WIDTH, so no aliasing. DEPTH_WORDS need not be a power of two.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x10 with wstrb 0xF and LATENCY 2, accepted at cycle T:
  - req_ready_o = 0 at T+1; resp_valid_o = 1 at T+2 with error 0 and rdata 0.
  - A following read of 0x10 returns 0xDEADBEEF.
- Partial write: wstrb 0x2, wdata 0x0000AA00 to 0x10 -> read of 0x10 returns 0xDEADAAEF.
- Backpressure: hold resp_ready_i = 0 for 5 cycles during a read response, and pulse req_valid_i during that time:
  - resp_valid_o, resp_rdata_o and resp_error_o stay stable and req_ready_o stays 0.
  - No extra response follows the release.
- Errors:
  - Read of 0x13 -> error 1, rdata 0.
  - Write of 0x1000 with DEPTH_WORDS 1024 -> error 1, and a read of word 0x0 is unchanged.
- Reset mid-operation: write 0x12345678 to 0x20 (previously 0xCAFEF00D) and assert rst_i during BUSY -> after reset, a read of 0x20 returns 0xCAFEF00D.
- Back-to-back with LATENCY 1 and resp_ready_i = 1:
  - Accept at T, response at T+1, accept of the next request at T+2.
  - Repeat with LATENCY 4 and confirm the response at T+4.
